// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and default parameter definitions for alu_arbiter
package alu_pkg;

    localparam int MUL_CYCLES_DEFAULT = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SLT = 4'h6,
        OP_BEQ = 4'h7,
        OP_BNE = 4'h8
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational operation evaluation: result, zero flag and illegal-op error
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        zero,
    output logic        err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_ADD:         result = {32'd0, a + b};
            OP_SUB:         result = {32'd0, a - b};
            OP_MUL:         result = 64'(a) * 64'(b);
            OP_AND:         result = {32'd0, a & b};
            OP_OR:          result = {32'd0, a | b};
            OP_XOR:         result = {32'd0, a ^ b};
            OP_SLT:         result = {63'd0, a < b};
            OP_BEQ, OP_BNE: result = '0;
            default:        err    = 1'b1;
        endcase
    end

    // Branch ops report the comparison through zero; everything else flags a zero result.
    always_comb begin
        case (op)
            OP_BEQ:  zero = (a == b);
            OP_BNE:  zero = (a != b);
            default: zero = (result == '0);
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU (IDLE/EXEC/RESP)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t      state;
    logic        last_id;
    logic        owner;
    logic        winner;
    logic        accept;
    logic        exec_done;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] core_result;
    logic        core_zero;
    logic        core_err;

    // On a tie the requester not served most recently wins.
    always_comb begin
        winner = ~last_id;
        if (req_valid == 2'b01) begin
            winner = 1'b0;
        end else if (req_valid == 2'b10) begin
            winner = 1'b1;
        end
    end

    assign req_ready = (state == S_IDLE) ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign exec_done = (op_q == OP_MUL) ? (cnt == MUL_LAST) : 1'b1;

    alu_core u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .zero   (core_zero),
        .err    (core_err)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_id    <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= winner ? req_op1 : req_op0;
                        a_q   <= winner ? req_a1 : req_a0;
                        b_q   <= winner ? req_b1 : req_b0;
                        owner <= winner;
                        cnt   <= '0;
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        rsp_result <= core_result;
                        rsp_zero   <= core_zero;
                        rsp_err    <= core_err;
                        rsp_valid  <= owner ? 2'b10 : 2'b01;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        last_id   <= owner;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int MUL_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0 = '0;
    logic [3:0]  req_op1 = '0;
    logic [31:0] req_a0 = '0;
    logic [31:0] req_a1 = '0;
    logic [31:0] req_b0 = '0;
    logic [31:0] req_b1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [63:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int checks  = 0;
    int errors  = 0;
    int last_id = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {err, zero, result} computed from plain 64-bit unsigned arithmetic.
    function automatic logic [65:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned r;
        logic            z;
        logic            e;
        ua = 64'(a);
        ub = 64'(b);
        r  = 0;
        e  = 1'b0;
        case (op)
            4'd0: r = (ua + ub) % 64'h1_0000_0000;
            4'd1: r = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000;
            4'd2: r = ua * ub;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: r = (ua < ub) ? 1 : 0;
            4'd7, 4'd8: r = 0;
            default: e = 1'b1;
        endcase
        if (op == 4'd7)      z = (a == b);
        else if (op == 4'd8) z = (a != b);
        else                 z = (r == 0);
        return {e, z, r};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst = 1'b0;
        cycle();
        cycle();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", rsp_result, 64'd0);
        check("rst_zero", 64'(rsp_zero), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        rst = 1'b1;
        last_id = 1;
    endtask

    // One full transaction: grant, EXEC latency, RESP held for `hold` extra cycles, handshake.
    task automatic serve(input logic [1:0] vmask,
                         input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold);
        int          w;
        int          lat;
        int          exp_lat;
        logic [1:0]  own;
        logic [65:0] exp;
        req_op0 = op0; req_a0 = a0; req_b0 = b0;
        req_op1 = op1; req_a1 = a1; req_b1 = b1;
        req_valid = vmask;
        rsp_ready = 2'b00;
        if (vmask == 2'b11) w = 1 - last_id;
        else                w = vmask[1] ? 1 : 0;
        own     = (w == 1) ? 2'b10 : 2'b01;
        exp     = (w == 1) ? model(op1, a1, b1) : model(op0, a0, b0);
        exp_lat = (((w == 1) ? op1 : op0) == 4'd2) ? 1 + MUL_CYCLES : 2;
        #1;
        check("grant", 64'(req_ready), 64'(own));
        cycle();
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 40) begin
            check("exec_busy", 64'(busy), 64'd1);
            check("exec_ready", 64'(req_ready), 64'd0);
            cycle();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", 64'(rsp_valid), 64'(own));
            check("result", rsp_result, exp[63:0]);
            check("zero", 64'(rsp_zero), 64'(exp[64]));
            check("err", 64'(rsp_err), 64'(exp[65]));
            check("resp_ready", 64'(req_ready), 64'd0);
            check("resp_busy", 64'(busy), 64'd1);
            if (i < hold) begin
                rsp_ready = ~own;
                cycle();
            end
        end
        rsp_ready = own;
        cycle();
        rsp_ready = 2'b00;
        check("rsp_done", 64'(rsp_valid), 64'd0);
        check("no_b2b_accept", 64'(busy), 64'd0);
        last_id = w;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m;
        logic [3:0]  o0, o1;
        logic [31:0] x0, y0, x1, y1;

        apply_reset();
        serve(2'b01, OP_ADD, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, 0);

        apply_reset();
        for (int k = 0; k < 4; k++)
            serve(2'b11, OP_SUB, 32'd3, 32'd3, OP_XOR, 32'hF0, 32'h0F, 0);

        serve(2'b01, OP_MUL, 32'hFFFF_FFFF, 32'd2, OP_ADD, 32'd0, 32'd0, 0);

        apply_reset();
        serve(2'b11, OP_OR, 32'h1234, 32'h8000_0000, OP_AND, 32'hFF00, 32'h0FF0, 5);
        serve(2'b10, OP_ADD, 32'd0, 32'd0, OP_AND, 32'hFF00, 32'h0FF0, 0);

        serve(2'b01, 4'hC, 32'd1, 32'd2, OP_ADD, 32'd0, 32'd0, 1);
        serve(2'b01, OP_BEQ, 32'd9, 32'd9, OP_ADD, 32'd0, 32'd0, 0);
        serve(2'b01, OP_BNE, 32'd9, 32'd9, OP_ADD, 32'd0, 32'd0, 0);

        // Reset lands on the edge closing the second EXEC cycle of a multiply.
        req_op0 = OP_MUL; req_a0 = 32'd6; req_b0 = 32'd7;
        req_valid = 2'b01;
        #1;
        check("mul_grant", 64'(req_ready), 64'd1);
        cycle();
        req_valid = 2'b00;
        cycle();
        rst = 1'b0;
        cycle();
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        last_id = 1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        serve(2'b11, OP_SLT, 32'd1, 32'd2, OP_SLT, 32'd2, 32'd1, 0);

        for (int it = 0; it < 40; it++) begin
            m  = 2'($urandom_range(1, 3));
            o0 = 4'($urandom_range(0, 15));
            o1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) o0 = OP_MUL;
            if ($urandom_range(0, 3) == 0) o1 = OP_MUL;
            x0 = $urandom;
            x1 = $urandom;
            y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
            y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            serve(m, o0, x0, y0, o1, x1, y1, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
